// File: rtl/jacobian_readout_pkg.sv
// rtl/jacobian_readout_pkg.sv - shared constants and types for the Jacobian frame readout
package jacobian_readout_pkg;
    localparam int ROWS         = 3;
    localparam int COLS         = 6;
    localparam int ENTRIES      = ROWS * COLS;
    localparam int IDX_W        = $clog2(ENTRIES);
    localparam int ADDR_STATUS  = ENTRIES;
    localparam int ADDR_RELEASE = ENTRIES + 1;

    localparam int STAT_CUR_FULL   = 0;
    localparam int STAT_OTHER_FULL = 1;
    localparam int STAT_OVF        = 2;
    localparam int STAT_ERR        = 3;
    localparam int STAT_SEQ_LSB    = 8;

    // Clear strobes in the STATUS write word sit one bit below their read positions.
    localparam int W1C_OVF = 1;
    localparam int W1C_ERR = 2;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;
    typedef enum logic {WR_CAPTURE = 1'b0, WR_DROP = 1'b1} wr_state_e;
endpackage

// File: rtl/jr_bank_ram.sv
// rtl/jr_bank_ram.sv - two-bank frame store, one write port and one registered read port
module jr_bank_ram #(
    parameter int DW    = 27,
    parameter int DEPTH = 18,
    parameter int IW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wbank,
    input  logic [IW-1:0] widx,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic          rbank,
    input  logic [IW-1:0] ridx,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [2][DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wbank][widx] <= wdata;
        end
        if (re) begin
            rdata <= mem_q[rbank][ridx];
        end
    end
endmodule

// File: rtl/jacobian_readout.sv
// rtl/jacobian_readout.sv - ping-pong capture of Jacobian frames with Avalon-MM host readout
module jacobian_readout
    import jacobian_readout_pkg::*;
#(
    parameter int DW = 27,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jac_valid,
    input  logic [DW-1:0] jac_data,
    input  logic          jac_last,
    input  logic [AW-1:0] avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    output logic [31:0]   avs_readdata,
    output logic          frame_irq
);
    wr_state_e        st_q, st_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    bank_state_e      bank_q [2];
    bank_state_e      bank_d [2];
    logic [7:0]       seq_q, seq_d;
    logic             ovf_q, ovf_d, err_q, err_d, irq_q;
    logic             rd_ent_q, rd_ent_d;
    logic [31:0]      rd_word_q, rd_word_d;

    logic             ram_we, good, ovf_set, err_set;
    logic             cur_full, last_idx, release_ok, w1c, addr_entry;
    logic [IDX_W-1:0] ram_ridx;
    logic [DW-1:0]    ram_rdata;
    logic [31:0]      status;
    logic             unused_wdata;

    assign cur_full   = (bank_q[rd_bank_q] == FULL);
    assign last_idx   = (idx_q == IDX_W'(ENTRIES - 1));
    assign release_ok = avs_write && (avs_address == AW'(ADDR_RELEASE)) && cur_full;
    assign w1c        = avs_write && (avs_address == AW'(ADDR_STATUS));
    assign addr_entry = (avs_address < AW'(ENTRIES));
    assign ram_ridx   = addr_entry ? IDX_W'(avs_address) : '0;
    assign unused_wdata = ^{avs_writedata[31:3], avs_writedata[0]};

    always_comb begin
        st_d      = st_q;
        idx_d     = idx_q;
        ram_we    = 1'b0;
        good      = 1'b0;
        ovf_set   = 1'b0;
        err_set   = 1'b0;
        bank_d    = bank_q;
        rd_bank_d = rd_bank_q;
        wr_bank_d = wr_bank_q;
        seq_d     = seq_q;
        if (jac_valid) begin
            case (st_q)
                WR_CAPTURE: begin
                    if (idx_q == '0 && bank_q[wr_bank_q] == FULL) begin
                        ovf_set = 1'b1;
                        if (!jac_last) st_d = WR_DROP;
                    end else begin
                        ram_we = 1'b1;
                        if (jac_last && last_idx) begin
                            good  = 1'b1;
                            idx_d = '0;
                        end else if (jac_last || last_idx) begin
                            err_set = 1'b1;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                WR_DROP: if (jac_last) st_d = WR_CAPTURE;
                default: st_d = WR_CAPTURE;
            endcase
        end
        if (release_ok) begin
            bank_d[rd_bank_q] = EMPTY;
            rd_bank_d         = ~rd_bank_q;
        end
        // A bank freed this cycle is as good as empty for the writer's next frame.
        if (good) begin
            bank_d[wr_bank_q] = FULL;
            seq_d             = seq_q + 8'd1;
            if (bank_q[~wr_bank_q] == EMPTY || release_ok) wr_bank_d = ~wr_bank_q;
        end else if (release_ok && bank_q[wr_bank_q] == FULL) begin
            wr_bank_d = ~wr_bank_q;
        end
        ovf_d = ovf_set || (ovf_q && !(w1c && avs_writedata[W1C_OVF]));
        err_d = err_set || (err_q && !(w1c && avs_writedata[W1C_ERR]));
    end

    always_comb begin
        status                       = '0;
        status[STAT_CUR_FULL]        = cur_full;
        status[STAT_OTHER_FULL]      = (bank_q[~rd_bank_q] == FULL);
        status[STAT_OVF]             = ovf_q;
        status[STAT_ERR]             = err_q;
        status[STAT_SEQ_LSB +: 8]    = seq_q;
    end

    assign rd_ent_d  = avs_read && addr_entry && cur_full;
    assign rd_word_d = (avs_read && avs_address == AW'(ADDR_STATUS)) ? status : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q      <= WR_CAPTURE;
            idx_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            seq_q     <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            rd_ent_q  <= 1'b0;
            rd_word_q <= '0;
        end else begin
            st_q      <= st_d;
            idx_q     <= idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            bank_q    <= bank_d;
            seq_q     <= seq_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            irq_q     <= cur_full;
            rd_ent_q  <= rd_ent_d;
            rd_word_q <= rd_word_d;
        end
    end

    jr_bank_ram #(.DW(DW), .DEPTH(ENTRIES), .IW(IDX_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .wbank (wr_bank_q),
        .widx  (idx_q),
        .wdata (jac_data),
        .re    (avs_read && addr_entry),
        .rbank (rd_bank_q),
        .ridx  (ram_ridx),
        .rdata (ram_rdata)
    );

    assign avs_readdata = rd_ent_q ? {{(32-DW){ram_rdata[DW-1]}}, ram_rdata} : rd_word_q;
    assign frame_irq    = irq_q;
endmodule
